// File: rtl/rocketcpu_bus_pkg.sv
// Shared definitions for the RocketCPU Wishbone decoder.
//   - wb_state_e          : decoder FSM state encoding (2 bits)
//   - WB_ERR_DATA_DEFAULT : read data returned on error-terminated accesses
//   - SOC_*               : SoC memory map (base/mask per peripheral) and the
//                           packed 8-slave tables used by the SoC top-level
package rocketcpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } wb_state_e;

    localparam logic [31:0] WB_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // SoC memory map: a slave matches when (adr & MASK) == BASE.
    localparam logic [31:0] SOC_RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] SOC_RAM_MASK   = 32'hFFFF_8000;  // 32 KiB
    localparam logic [31:0] SOC_FLASH_BASE = 32'h4000_0000;
    localparam logic [31:0] SOC_FLASH_MASK = 32'hFF00_0000;  // 16 MiB window
    localparam logic [31:0] SOC_SPI_BASE   = 32'h4100_0000;
    localparam logic [31:0] SOC_SPI_MASK   = 32'hFFFF_FF00;
    localparam logic [31:0] SOC_UART_BASE  = 32'h4200_0000;
    localparam logic [31:0] SOC_UART_MASK  = 32'hFFFF_FFF0;
    localparam logic [31:0] SOC_GPIO_BASE  = 32'h4300_0000;
    localparam logic [31:0] SOC_GPIO_MASK  = 32'hFFFF_FFF0;
    localparam logic [31:0] SOC_TIMER_BASE = 32'h4400_0000;
    localparam logic [31:0] SOC_TIMER_MASK = 32'hFFFF_FFE0;
    localparam logic [31:0] SOC_IRQ_BASE   = 32'h4500_0000;
    localparam logic [31:0] SOC_IRQ_MASK   = 32'hFFFF_FFF0;
    localparam logic [31:0] SOC_AUDIO_BASE = 32'h4600_0000;
    localparam logic [31:0] SOC_AUDIO_MASK = 32'hFFFF_FF00;

    localparam int unsigned SOC_NUM_SLAVES = 8;

    // Slot 0 is the rightmost 32-bit field.
    localparam logic [SOC_NUM_SLAVES*32-1:0] SOC_SLAVE_BASE = {
        SOC_AUDIO_BASE, SOC_IRQ_BASE, SOC_TIMER_BASE, SOC_GPIO_BASE,
        SOC_UART_BASE, SOC_SPI_BASE, SOC_FLASH_BASE, SOC_RAM_BASE
    };
    localparam logic [SOC_NUM_SLAVES*32-1:0] SOC_SLAVE_MASK = {
        SOC_AUDIO_MASK, SOC_IRQ_MASK, SOC_TIMER_MASK, SOC_GPIO_MASK,
        SOC_UART_MASK, SOC_SPI_MASK, SOC_FLASH_MASK, SOC_RAM_MASK
    };

endpackage

// File: rtl/rocketcpu_wb_decoder_if.sv
// Master-side Wishbone bus between the arbiter and the decoder.
//   adr/dat/sel/we/cyc : request from the master
//   rdt/ack/err        : response to the master (err only valid with ack)
// Modports: master (arbiter side), slave (decoder side).
interface rocketcpu_wb_decoder_if;

    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat, sel, we, cyc,
        input  rdt, ack, err
    );

    modport slave (
        input  adr, dat, sel, we, cyc,
        output rdt, ack, err
    );

endinterface

// File: rtl/rocketcpu_wb_addr_match.sv
// Combinational base/mask address decoder.
//   i_adr   : address to decode
//   o_match : one-hot-or-more vector, bit i set when (i_adr & MASK[i]) == BASE[i]
//   o_idx   : index of the lowest matching slot (0 when none)
//   o_hit   : at least one slot matched
module rocketcpu_wb_addr_match #(
    parameter int unsigned                NUM_SLAVES = 8,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = '0,
    localparam int unsigned               IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [31:0]           i_adr,
    output logic [NUM_SLAVES-1:0] o_match,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_hit
);

    always_comb begin
        o_match = '0;
        o_idx   = '0;
        o_hit   = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            o_match[i] = ((i_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]);
            // Ascending scan: first hit fixes the index, so the lowest slot wins.
            if (o_match[i] && !o_hit) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rocketcpu_wb_decoder.sv
// Wishbone slave-select and response block between the arbiter and N slaves.
//   i_wb_clk, i_wb_rst_n : clock, asynchronous active-low reset
//   wb                   : master bus (request in, registered rdt/ack/err out)
//   o_s_cyc              : one-hot slave cycle, only while an access is ACTIVE
//   o_s_adr/dat/sel/we   : request broadcast to all slaves
//   i_s_rdt, i_s_ack     : packed slave read data (slot i at [32*i+:32]) / acks
//   o_err_flag/o_err_adr : sticky error status and first error address
//   i_err_clr            : synchronous clear of the error status
// Unmapped accesses and slaves that never ack are terminated with ack+err so
// the master can never stall.
module rocketcpu_wb_decoder
    import rocketcpu_bus_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'h0}},
    parameter int unsigned              TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_DATA       = WB_ERR_DATA_DEFAULT
) (
    input  logic                       i_wb_clk,
    input  logic                       i_wb_rst_n,
    rocketcpu_wb_decoder_if.slave      wb,
    output logic [NUM_SLAVES-1:0]      o_s_cyc,
    output logic [31:0]                o_s_adr,
    output logic [31:0]                o_s_dat,
    output logic [3:0]                 o_s_sel,
    output logic                       o_s_we,
    input  logic [NUM_SLAVES*32-1:0]   i_s_rdt,
    input  logic [NUM_SLAVES-1:0]      i_s_ack,
    output logic                       o_err_flag,
    output logic [31:0]                o_err_adr,
    input  logic                       i_err_clr
);

    localparam int unsigned IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    wb_state_e        state_q,    state_d;
    logic [IDX_W-1:0] sel_q,      sel_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      rdt_q,      rdt_d;
    logic             ack_q,      ack_d;
    logic             err_q,      err_d;
    logic             err_flag_q, err_flag_d;
    logic [31:0]      err_adr_q,  err_adr_d;

    logic [NUM_SLAVES-1:0] match;
    logic [IDX_W-1:0]      match_idx;
    logic                  match_hit;
    logic [31:0]           sel_rdt;
    logic                  sel_ack;
    logic                  err_event;

    rocketcpu_wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_addr_match (
        .i_adr   (wb.adr),
        .o_match (match),
        .o_idx   (match_idx),
        .o_hit   (match_hit)
    );

    // Mux out the latched slave; acks from other slots never reach the FSM.
    // o_s_cyc also follows wb.cyc so an aborted access is not extended to
    // the slave for the cycle before the FSM returns to IDLE.
    always_comb begin
        sel_rdt = '0;
        sel_ack = 1'b0;
        o_s_cyc = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (IDX_W'(i) == sel_q) begin
                sel_rdt    = i_s_rdt[32*i +: 32];
                sel_ack    = i_s_ack[i];
                o_s_cyc[i] = (state_q == ST_ACTIVE) && wb.cyc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rdt_d      = rdt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;
        err_adr_d  = err_adr_q;
        err_event  = 1'b0;

        if (i_err_clr) begin
            err_flag_d = 1'b0;
            err_adr_d  = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (wb.cyc) begin
                    if (match_hit) begin
                        state_d = ST_ACTIVE;
                        sel_d   = match_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d   = ST_RESP;
                        err_event = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!wb.cyc) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    // Checked before the timeout so a last-cycle ack wins.
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    rdt_d   = sel_rdt;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_RESP;
                    err_event = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error overrides a coincident clear.
        if (err_event) begin
            ack_d = 1'b1;
            err_d = 1'b1;
            rdt_d = ERR_DATA;
            if (!err_flag_q || i_err_clr) begin
                err_flag_d = 1'b1;
                err_adr_d  = wb.adr;
            end
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_adr_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
            err_adr_q  <= err_adr_d;
        end
    end

    assign wb.rdt     = rdt_q;
    assign wb.ack     = ack_q;
    assign wb.err     = err_q;
    assign o_s_adr    = wb.adr;
    assign o_s_dat    = wb.dat;
    assign o_s_sel    = wb.sel;
    assign o_s_we     = wb.we;
    assign o_err_flag = err_flag_q;
    assign o_err_adr  = err_adr_q;

endmodule

// File: tb/tb_rocketcpu_wb_decoder.sv
// Directed bench for rocketcpu_wb_decoder: 3 slaves (slot 0 = 32 KiB RAM at 0,
// slots 1 and 2 overlap exactly at 0x0400_0000), timeout of 4 cycles.
module tb_rocketcpu_wb_decoder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  s_cyc;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic        s_we;
    logic [95:0] s_rdt_bus;
    logic [2:0]  s_ack;
    logic        err_flag;
    logic [31:0] err_adr;
    logic        err_clr;

    logic [2:0]  ack_en;
    logic [2:0]  ack_force;
    logic [31:0] s_rdt [3];

    int n_chk  = 0;
    int n_fail = 0;

    rocketcpu_wb_decoder_if wb_bus();

    rocketcpu_wb_decoder #(
        .NUM_SLAVES     (3),
        .SLAVE_BASE     ({32'h0400_0000, 32'h0400_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_8000}),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .wb         (wb_bus),
        .o_s_cyc    (s_cyc),
        .o_s_adr    (s_adr),
        .o_s_dat    (s_dat),
        .o_s_sel    (s_sel),
        .o_s_we     (s_we),
        .i_s_rdt    (s_rdt_bus),
        .i_s_ack    (s_ack),
        .o_err_flag (err_flag),
        .o_err_adr  (err_adr),
        .i_err_clr  (err_clr)
    );

    // Slave model: combinational ack while selected, plus forced acks.
    always_comb s_ack = (s_cyc & ack_en) | ack_force;
    assign s_rdt_bus = {s_rdt[2], s_rdt[1], s_rdt[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one access from IDLE; lat is the cycle index (cyc cycle = 0) of ack.
    task automatic do_access(input logic [31:0] adr, input logic we,
                             output int lat, output logic [31:0] rdt, output logic err,
                             output logic [2:0] seen, output int ncyc, output logic ack_after);
        bit done;
        done = 1'b0;
        lat = -1; rdt = '0; err = 1'b0; seen = '0; ncyc = 0;
        wb_bus.adr = adr; wb_bus.we = we; wb_bus.dat = 32'h0BEE_F00D;
        wb_bus.sel = 4'hF; wb_bus.cyc = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            #2;
            seen = seen | s_cyc;
            if (s_cyc != 3'b000) ncyc++;
            if (wb_bus.ack) begin
                lat = n; rdt = wb_bus.rdt; err = wb_bus.err; done = 1'b1;
                wb_bus.cyc = 1'b0;
            end
            @(posedge clk);
            #2;
        end
        wb_bus.cyc = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL access_budget: no ack for adr 0x%08h within 20 cycles", adr);
        end
        #2;
        ack_after = wb_bus.ack;
        tick();
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [2:0]  ack_en;
        logic [2:0]  ack_force;
        int          lat;
        logic [31:0] rdt;
        logic        err;
        logic [2:0]  seen;
        int          ncyc;
        logic        flag;
        logic [31:0] eadr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          lat, ncyc;
        logic [31:0] rdt;
        logic        err, ack_after;
        logic [2:0]  seen;

        //          adr           we    ack_en  force   lat rdt            err   seen    n  flag  eadr
        vecs[0] = '{32'h0000_0100, 1'b0, 3'b111, 3'b000, 2, 32'h1234_5678, 1'b0, 3'b001, 1, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_7FFC, 1'b1, 3'b111, 3'b000, 2, 32'h1234_5678, 1'b0, 3'b001, 1, 1'b0, 32'h0};
        vecs[2] = '{32'h0400_0000, 1'b0, 3'b111, 3'b000, 2, 32'hA5A5_0001, 1'b0, 3'b010, 1, 1'b0, 32'h0};
        vecs[3] = '{32'h0600_0000, 1'b0, 3'b111, 3'b000, 1, 32'hDEAD_BEEF, 1'b1, 3'b000, 0, 1'b1, 32'h0600_0000};
        vecs[4] = '{32'h0400_0004, 1'b0, 3'b111, 3'b000, 1, 32'hDEAD_BEEF, 1'b1, 3'b000, 0, 1'b1, 32'h0600_0000};
        vecs[5] = '{32'h0700_0000, 1'b1, 3'b111, 3'b000, 1, 32'hDEAD_BEEF, 1'b1, 3'b000, 0, 1'b1, 32'h0600_0000};
        vecs[6] = '{32'h0000_0200, 1'b0, 3'b000, 3'b000, 5, 32'hDEAD_BEEF, 1'b1, 3'b001, 4, 1'b1, 32'h0600_0000};
        vecs[7] = '{32'h0400_0000, 1'b0, 3'b000, 3'b100, 5, 32'hDEAD_BEEF, 1'b1, 3'b010, 4, 1'b1, 32'h0600_0000};
        vecs[8] = '{32'h0400_0000, 1'b0, 3'b010, 3'b000, 2, 32'hA5A5_0001, 1'b0, 3'b010, 1, 1'b1, 32'h0600_0000};

        s_rdt[0] = 32'h1234_5678;
        s_rdt[1] = 32'hA5A5_0001;
        s_rdt[2] = 32'h0BAD_0002;
        ack_en = '0; ack_force = '0; err_clr = 1'b0;
        wb_bus.adr = '0; wb_bus.dat = '0; wb_bus.sel = '0; wb_bus.we = 1'b0; wb_bus.cyc = 1'b0;

        // Reset state
        rst_n = 1'b0;
        #3;
        chk("rst_ack",   {31'b0, wb_bus.ack}, 32'h0);
        chk("rst_err",   {31'b0, wb_bus.err}, 32'h0);
        chk("rst_rdt",   wb_bus.rdt, 32'h0);
        chk("rst_s_cyc", {29'b0, s_cyc}, 32'h0);
        chk("rst_flag",  {31'b0, err_flag}, 32'h0);
        chk("rst_eadr",  err_adr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven single accesses
        for (int i = 0; i < 9; i++) begin
            ack_en = vecs[i].ack_en;
            ack_force = vecs[i].ack_force;
            do_access(vecs[i].adr, vecs[i].we, lat, rdt, err, seen, ncyc, ack_after);
            ack_force = '0;
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_rdt", i), rdt, vecs[i].rdt);
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
            chk($sformatf("v%0d_s_cyc_seen", i), {29'b0, seen}, {29'b0, vecs[i].seen});
            chk($sformatf("v%0d_s_cyc_cycles", i), ncyc, vecs[i].ncyc);
            chk($sformatf("v%0d_ack_one_cycle", i), {31'b0, ack_after}, 32'h0);
            chk($sformatf("v%0d_err_flag", i), {31'b0, err_flag}, {31'b0, vecs[i].flag});
            chk($sformatf("v%0d_err_adr", i), err_adr, vecs[i].eadr);
        end

        // Ack in the final timeout cycle wins over the timeout
        ack_en = '0;
        s_rdt[1] = 32'h5555_AAAA;
        wb_bus.adr = 32'h0400_0000; wb_bus.we = 1'b0; wb_bus.cyc = 1'b1;
        tick(); tick(); tick(); tick();
        ack_force = 3'b010;
        tick();
        ack_force = '0;
        wb_bus.cyc = 1'b0;
        chk("lastcyc_ack", {31'b0, wb_bus.ack}, 32'h1);
        chk("lastcyc_err", {31'b0, wb_bus.err}, 32'h0);
        chk("lastcyc_rdt", wb_bus.rdt, 32'h5555_AAAA);
        tick();

        // Error clear
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_flag", {31'b0, err_flag}, 32'h0);
        chk("clr_eadr", err_adr, 32'h0);

        // Fresh error, then clear coincident with a new error
        do_access(32'h0700_0000, 1'b0, lat, rdt, err, seen, ncyc, ack_after);
        chk("err2_flag", {31'b0, err_flag}, 32'h1);
        chk("err2_eadr", err_adr, 32'h0700_0000);
        wb_bus.adr = 32'h0900_0000; wb_bus.cyc = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0; wb_bus.cyc = 1'b0;
        chk("clrhit_ack", {31'b0, wb_bus.ack}, 32'h1);
        chk("clrhit_err", {31'b0, wb_bus.err}, 32'h1);
        chk("clrhit_flag", {31'b0, err_flag}, 32'h1);
        chk("clrhit_eadr", err_adr, 32'h0900_0000);
        tick();

        // Master abort in ACTIVE, with broadcast checks
        ack_en = '0;
        wb_bus.adr = 32'h0400_0000; wb_bus.we = 1'b1; wb_bus.dat = 32'hCAFE_F00D;
        wb_bus.sel = 4'h3; wb_bus.cyc = 1'b1;
        tick();
        chk("abort_s_cyc", {29'b0, s_cyc}, 32'h2);
        chk("abort_s_adr", s_adr, 32'h0400_0000);
        chk("abort_s_dat", s_dat, 32'hCAFE_F00D);
        chk("abort_s_sel_we", {27'b0, s_sel, s_we}, 32'h7);
        wb_bus.cyc = 1'b0;
        #1;
        chk("abort_s_cyc_drop", {29'b0, s_cyc}, 32'h0);
        tick();
        chk("abort_no_ack1", {30'b0, wb_bus.ack, wb_bus.err}, 32'h0);
        tick();
        chk("abort_no_ack2", {30'b0, wb_bus.ack, wb_bus.err}, 32'h0);
        ack_en = 3'b010;
        do_access(32'h0400_0000, 1'b0, lat, rdt, err, seen, ncyc, ack_after);
        chk("after_abort_lat", lat, 2);
        chk("after_abort_rdt", rdt, 32'h5555_AAAA);
        chk("after_abort_err", {31'b0, err}, 32'h0);

        // Asynchronous reset in ACTIVE
        ack_en = '0;
        wb_bus.adr = 32'h0000_0100; wb_bus.we = 1'b0; wb_bus.cyc = 1'b1;
        tick();
        chk("arst_pre_s_cyc", {29'b0, s_cyc}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_s_cyc", {29'b0, s_cyc}, 32'h0);
        chk("arst_ack",   {31'b0, wb_bus.ack}, 32'h0);
        chk("arst_flag",  {31'b0, err_flag}, 32'h0);
        chk("arst_eadr",  err_adr, 32'h0);
        chk("arst_rdt",   wb_bus.rdt, 32'h0);
        wb_bus.cyc = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_idle_s_cyc", {29'b0, s_cyc}, 32'h0);
        ack_en = 3'b001;
        do_access(32'h0000_0100, 1'b0, lat, rdt, err, seen, ncyc, ack_after);
        chk("arst_next_lat", lat, 2);
        chk("arst_next_rdt", rdt, 32'h1234_5678);
        chk("arst_next_seen", {29'b0, seen}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
